// File: rtl/fp_switch_arbiter.sv
// fp_switch_arbiter: wormhole-locking switch arbiter for one mesh router output port (ripple-chain priority).
// Latency: grant registered 1 cycle after request; one idle bubble cycle between consecutive packets.
// Backpressure: i_ready low or a stalled requester holds the grant; release only on an accepted tail flit.
// Option: define FP_SWITCH_ARBITER_ROUND_ROBIN_EN for rotating priority (pointer moves past each released winner).
module fp_switch_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N-1:0]     i_req,
   input  logic [N-1:0]     i_tail,
   input  logic             i_ready,
   output logic [N-1:0]     o_grant,
   output logic             o_grant_valid,
   output logic [IDX_W-1:0] o_grant_idx,
   output logic             o_xfer
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state_q;
   logic [N-1:0]     grant_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] ptr;

   logic [N-1:0]     req_rot;
   logic [N-1:0]     carry;
   logic [N-1:0]     gnt_rot;
   logic [N-1:0]     grant_d;
   logic [IDX_W-1:0] idx_d;
   logic             release_pkt;

   // (a + b) mod N, sized as a requester index
   function automatic logic [IDX_W-1:0] wrap_add(input int a, input int b);
      return IDX_W'((a + b) % N);
   endfunction

`ifdef FP_SWITCH_ARBITER_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_q;
   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   // Rotate requests so the current priority start point sits at chain position 0
   always_comb begin
      req_rot = '0;
      for (int i = 0; i < N; i++) begin
         req_rot[i] = i_req[wrap_add(i, int'(ptr))];
      end
   end

   // Ripple chain: a cell wins if it requests and no earlier cell requested
   always_comb begin
      carry    = '0;
      carry[0] = 1'b1;
      for (int i = 1; i < N; i++) begin
         carry[i] = carry[i-1] & ~req_rot[i-1];
      end
      gnt_rot = req_rot & carry;
   end

   // Rotate the winner back to requester numbering and encode its index
   always_comb begin
      grant_d = '0;
      idx_d   = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_rot[i]) begin
            grant_d[wrap_add(i, int'(ptr))] = 1'b1;
            idx_d                           = wrap_add(i, int'(ptr));
         end
      end
   end

   // A flit moves when the held winner still requests and downstream accepts
   assign o_xfer      = o_grant_valid & i_req[idx_q] & i_ready;
   assign release_pkt = o_xfer & i_tail[idx_q];

   // Lock FSM: load the winner in IDLE, hold it until its tail flit is accepted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
`ifdef FP_SWITCH_ARBITER_ROUND_ROBIN_EN
         ptr_q   <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (|i_req) begin
                  grant_q <= grant_d;
                  idx_q   <= idx_d;
                  state_q <= LOCKED;
               end
            end
            LOCKED: begin
               if (release_pkt) begin
                  grant_q <= '0;
                  idx_q   <= '0;
                  state_q <= IDLE;
`ifdef FP_SWITCH_ARBITER_ROUND_ROBIN_EN
                  ptr_q   <= (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
`endif
               end
            end
            default: begin
               grant_q <= '0;
               idx_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_grant       = grant_q;
   assign o_grant_idx   = idx_q;
   assign o_grant_valid = |grant_q;

endmodule

// File: tb/tb_fp_switch_arbiter.sv
// tb_fp_switch_arbiter: directed checks of fp_switch_arbiter with N=4.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled away from the edge.
// Expected values are hand-derived from the arbiter behaviour (fixed or round-robin priority).
module tb_fp_switch_arbiter;

   localparam int N     = 4;
   localparam int IDX_W = 2;

   logic             clk;
   logic             reset_n;
   logic [N-1:0]     i_req;
   logic [N-1:0]     i_tail;
   logic             i_ready;
   logic [N-1:0]     o_grant;
   logic             o_grant_valid;
   logic [IDX_W-1:0] o_grant_idx;
   logic             o_xfer;

   int checks = 0;
   int errors = 0;

   fp_switch_arbiter #(.N(N), .IDX_W(IDX_W)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_req         (i_req),
      .i_tail        (i_tail),
      .i_ready       (i_ready),
      .o_grant       (o_grant),
      .o_grant_valid (o_grant_valid),
      .o_grant_idx   (o_grant_idx),
      .o_xfer        (o_xfer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_grant(input string tag, input logic [N-1:0] g, input logic [IDX_W-1:0] idx);
      check({tag, "_grant"}, 32'(o_grant), 32'(g));
      check({tag, "_valid"}, 32'(o_grant_valid), 32'(|g));
      check({tag, "_idx"}, 32'(o_grant_idx), 32'(idx));
   endtask

   logic [IDX_W-1:0] rr_exp [5];

   initial begin
`ifdef FP_SWITCH_ARBITER_ROUND_ROBIN_EN
      rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
      rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
      // Reset with all requests high
      reset_n = 1'b0;
      i_req   = 4'b1111;
      i_tail  = 4'b0000;
      i_ready = 1'b1;
      tick();
      tick();
      check_grant("reset", 4'b0000, 2'd0);
      check("reset_xfer", 32'(o_xfer), 32'd0);

      reset_n = 1'b1;
      i_req   = 4'b0000;
      tick();
      check_grant("idle", 4'b0000, 2'd0);

      // Basic grant: req 1 beats req 2, three-flit packet
      i_req = 4'b0110;
      #1;
      check_grant("latency", 4'b0000, 2'd0);
      tick();
      check_grant("basic_f1", 4'b0010, 2'd1);
      check("basic_f1_xfer", 32'(o_xfer), 32'd1);
      tick();
      check_grant("basic_f2", 4'b0010, 2'd1);
      tick();
      i_tail = 4'b0010;
      #1;
      check_grant("basic_f3", 4'b0010, 2'd1);
      check("basic_f3_xfer", 32'(o_xfer), 32'd1);
      tick();
      i_req  = 4'b0100;
      i_tail = 4'b0000;
      check_grant("bubble", 4'b0000, 2'd0);
      tick();
      check_grant("next_pkt", 4'b0100, 2'd2);

      // No preemption; a non-granted tail is ignored
      i_req  = 4'b0101;
      i_tail = 4'b0001;
      #1;
      check("nopre_xfer", 32'(o_xfer), 32'd1);
      tick();
      check_grant("nopre", 4'b0100, 2'd2);

      // Downstream stall with the tail pending
      i_ready = 1'b0;
      i_tail  = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("stall_xfer", 32'(o_xfer), 32'd0);
         tick();
         check_grant("stall", 4'b0100, 2'd2);
      end

      // Granted requester drops its request: held, no transfer
      i_ready = 1'b1;
      i_req   = 4'b0001;
      #1;
      check("drop_xfer", 32'(o_xfer), 32'd0);
      tick();
      check_grant("drop", 4'b0100, 2'd2);

      // Tail accepted: release
      i_req = 4'b0101;
      #1;
      check("tail_xfer", 32'(o_xfer), 32'd1);
      tick();
      i_req  = 4'b0000;
      i_tail = 4'b0000;
      check_grant("release", 4'b0000, 2'd0);
      tick();
      check_grant("idle2", 4'b0000, 2'd0);

      // Single-flit packet on req 3
      i_req  = 4'b1000;
      i_tail = 4'b1000;
      tick();
      check_grant("single", 4'b1000, 2'd3);
      check("single_xfer", 32'(o_xfer), 32'd1);
      tick();
      i_req  = 4'b0000;
      i_tail = 4'b0000;
      check_grant("single_rel", 4'b0000, 2'd0);
      tick();
      check_grant("single_idle", 4'b0000, 2'd0);

      // Asynchronous reset mid-packet
      i_req = 4'b0010;
      tick();
      check_grant("pre_arst", 4'b0010, 2'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_grant("arst", 4'b0000, 2'd0);
      #1;
      reset_n = 1'b1;
      tick();
      check_grant("post_arst", 4'b0010, 2'd1);
      i_tail = 4'b0010;
      tick();
      i_req  = 4'b0000;
      i_tail = 4'b0000;
      check_grant("post_arst_rel", 4'b0000, 2'd0);

      // Clean reset so the priority start point is index 0
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      tick();

      // All requesting, every packet single-flit
      i_req  = 4'b1111;
      i_tail = 4'b1111;
      for (int p = 0; p < 5; p++) begin
         tick();
         check_grant("rr", 4'(1 << rr_exp[p]), rr_exp[p]);
         tick();
         check_grant("rr_gap", 4'b0000, 2'd0);
      end
      i_req  = 4'b0000;
      i_tail = 4'b0000;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_switch_arbiter.md
Name: fp_switch_arbiter

Overview:
- N-input switch arbiter for one mesh router output port.
- Sits directly downstream of the input-port request logic and upstream of the crossbar mux select.
- Priority choice uses the same ripple chain of per-requester cells: grant_i = r_i & c_i; c_(i+1) = ~r_i & c_i; c_0 = 1.
- Adds wormhole locking: the winner's grant is registered and held until that requester's tail flit is accepted downstream.

Parameters:
- N, 4: number of requesters (input ports); legal range 2..16.
- IDX_W, $clog2(N): width of the encoded grant index.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  reset; asynchronous assert, active-low.
- i_req  input  N  per-requester request; bit i high while input i holds a flit for this output.
- i_tail  input  N  per-requester flag; bit i high when input i's current flit is a tail.
- i_ready  input  1  downstream accepts the current flit this cycle.
- o_grant  output  N  registered one-hot grant; all-zero when idle.
- o_grant_valid  output  1  high while a grant is held (equals |o_grant).
- o_grant_idx  output  IDX_W  binary index of the granted requester; 0 when idle.
- o_xfer  output  1  combinational; o_grant_valid & i_req[idx] & i_ready (a flit moves this cycle).

Behaviour:
- Reset (reset_n low, at any time including mid-packet):
  - o_grant = 0, o_grant_valid = 0, o_grant_idx = 0.
  - State = IDLE; optional priority pointer = 0.
  - Outputs change immediately, without waiting for a clock edge.
- States: IDLE, LOCKED.
- IDLE:
  - Ripple chain evaluates i_req; index 0 has highest priority.
  - If any request is high: the winner is loaded into o_grant/o_grant_idx at the next edge; go to LOCKED.
  - Grant latency is 1 cycle from request to o_grant_valid.
  - If no request is high: remain in IDLE with outputs 0.
- LOCKED:
  - Grant is held unchanged regardless of other requests; no preemption by a higher-priority requester.
  - Release condition: o_xfer & i_tail[idx]. On release, next state = IDLE and o_grant clears at the next edge.
  - A new arbitration then takes one further cycle: one bubble cycle between packets.
  - Granted requester drops i_req without a tail: grant is held (packet stalled, not aborted); o_xfer = 0.
  - i_ready low: grant is held; no transfer.
  - Single-flit packet (i_tail high on the head flit) with i_ready high in the first LOCKED cycle: release after one transfer.
- i_tail bits of non-granted requesters are ignored.
- o_grant is always one-hot or zero; it never has more than one bit set.
- Simultaneous release and new requests: the new requests are evaluated in the following IDLE cycle, never in the release cycle.

Optional Feature:
- Macro: FP_SWITCH_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - An IDX_W pointer register, reset 0, sets the priority start point.
  - Arbitration starts at index ptr and wraps modulo N; this is implemented by rotating i_req by ptr before the ripple chain and rotating the grant back.
  - On release, ptr <= (idx + 1) mod N, so idx = N-1 wraps to 0.
- Undefined:
  - No pointer register; fixed priority with index 0 highest.

Test Plan (N=4):
- Reset values: hold reset_n low, drive i_req=4'b1111 -> o_grant=0, o_grant_valid=0, o_grant_idx=0.
- Basic grant and release: i_req=4'b0110, i_ready=1, tail on the 3rd flit of req 1 -> o_grant=4'b0010 one cycle after request; held 3 cycles; cleared the cycle after the tail; 4'b0100 granted the following cycle.
- No preemption and stall: while req 2 is locked, raise req 0 -> grant stays 4'b0100. Drive i_ready=0 for 5 cycles -> grant held, o_xfer=0 throughout.
- Single-flit packet: i_req=4'b1000, i_tail=4'b1000, i_ready=1 -> o_grant=4'b1000 for exactly 1 cycle, then 0.
- Async reset mid-packet: pulse reset_n low between clock edges during LOCKED -> o_grant=0 immediately; after release from reset, arbitration restarts from IDLE.
- Round-robin (macro defined): i_req=4'b1111 held, every packet single-flit -> grant sequence 0,1,2,3,0 (wrap). Macro undefined -> grant sequence 0,0,0.
